// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one shared 8-bit Fibonacci LFSR (taps 7,5,4,3), round-robin
// arbitrated among NUM_REQ requesters. Each winner receives one number uniform
// in [0, range-1], drawn by masked rejection sampling with a bounded fallback.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req[NUM_REQ]        level requests, held until gnt
//   req_range           per-requester range, [i*WIDTH +: WIDTH]; 0 = full range
//   gnt, rnd_valid      one-cycle grant pulse and matching result strobe
//   rnd_out             result, held until the next rnd_valid
//   busy                high while a draw is in flight (DRAW/DONE)
//   lfsr_state          current LFSR register
// Optional: define RNG_ARB_RESEED_EN to add seed_load/seed_value for reseeding.
module lfsr_rng_arbiter #(
   parameter int unsigned       NUM_REQ   = 4,
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  SEED      = WIDTH'(8'h01),
   parameter int unsigned       MAX_TRIES = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_range,
`ifdef RNG_ARB_RESEED_EN
   input  logic                     seed_load,
   input  logic [WIDTH-1:0]         seed_value,
`endif
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     rnd_valid,
   output logic [WIDTH-1:0]         rnd_out,
   output logic                     busy,
   output logic [WIDTH-1:0]         lfsr_state
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [PW-1:0]      rr_q, rr_d;
   logic [PW-1:0]      win_q, win_d;
   logic [WIDTH-1:0]   rng_q, rng_d;
   logic [TW-1:0]      tries_q, tries_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               vld_q, vld_d;
   logic               busy_q, busy_d;

   logic [WIDTH-1:0]   rng_arr [NUM_REQ];
   logic [PW-1:0]      pick;
   logic               found;
   logic [WIDTH-1:0]   mask;
   logic [WIDTH-1:0]   cand;
   logic               fb;

   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         rng_arr[i] = req_range[i*WIDTH +: WIDTH];
      end
   end

   // First set request at or after the round-robin pointer, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         int unsigned j;
         j = (int'(rr_q) + k) % NUM_REQ;
         if (!found && req[PW'(j)]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   // Smear (rng-1) rightwards: smallest 2^k-1 covering rng-1.
   // rng=0 wraps to all ones, rng=1 gives 0.
   always_comb begin
      mask = rng_q - WIDTH'(1);
      for (int s = 1; s < int'(WIDTH); s = s * 2) begin
         mask = mask | (mask >> s);
      end
   end

   assign cand = lfsr_q & mask;
   assign fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_comb begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
`ifdef RNG_ARB_RESEED_EN
      if (seed_load) begin
         lfsr_d = (seed_value == '0) ? SEED : seed_value;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      rng_d   = rng_q;
      tries_d = tries_q;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               win_d   = pick;
               rng_d   = rng_arr[pick];
               tries_d = '0;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (!req[win_q]) begin
               state_d = IDLE;
            end else if (rng_q == '0 || cand < rng_q) begin
               out_d   = cand;
               state_d = DONE;
            end else if (tries_q == TW'(MAX_TRIES - 1)) begin
               // mask < 2*rng, so one subtraction lands below rng
               out_d   = cand - rng_q;
               state_d = DONE;
            end else begin
               tries_d = tries_q + TW'(1);
            end
         end
         DONE: begin
            rr_d    = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered from the next state so they line up with it.
      gnt_d  = (state_d == DONE) ? (NUM_REQ'(1) << win_d) : '0;
      vld_d  = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         rr_q    <= '0;
         win_q   <= '0;
         rng_q   <= '0;
         tries_q <= '0;
         out_q   <= '0;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         rng_q   <= rng_d;
         tries_q <= tries_d;
         out_q   <= out_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt        = gnt_q;
   assign rnd_valid  = vld_q;
   assign rnd_out    = out_q;
   assign busy       = busy_q;
   assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: vector table, hand sequences and a transaction-level
// random model for lfsr_rng_arbiter (MAX_TRIES=16 and MAX_TRIES=1 instances).
module tb_lfsr_rng_arbiter;

   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NR-1:0] req = '0;
   logic [31:0]   req_range = '0;
`ifdef RNG_ARB_RESEED_EN
   logic          seed_load = 1'b0;
   logic [7:0]    seed_value = '0;
`endif

   logic [NR-1:0] gnt_a, gnt_b, gnt_m;
   logic          vld_a, vld_b, vld_m;
   logic [7:0]    out_a, out_b, out_m;
   logic          busy_a, busy_b, busy_m;
   logic [7:0]    lfsr_a, lfsr_b, lfsr_m;
   bit            sel = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lfsr_rng_arbiter #(.NUM_REQ(NR), .WIDTH(8), .SEED(8'h01), .MAX_TRIES(16)) u_a (
      .clk(clk), .reset_n(reset_n), .req(req), .req_range(req_range),
`ifdef RNG_ARB_RESEED_EN
      .seed_load(seed_load), .seed_value(seed_value),
`endif
      .gnt(gnt_a), .rnd_valid(vld_a), .rnd_out(out_a),
      .busy(busy_a), .lfsr_state(lfsr_a));

   lfsr_rng_arbiter #(.NUM_REQ(NR), .WIDTH(8), .SEED(8'h01), .MAX_TRIES(1)) u_b (
      .clk(clk), .reset_n(reset_n), .req(req), .req_range(req_range),
`ifdef RNG_ARB_RESEED_EN
      .seed_load(seed_load), .seed_value(seed_value),
`endif
      .gnt(gnt_b), .rnd_valid(vld_b), .rnd_out(out_b),
      .busy(busy_b), .lfsr_state(lfsr_b));

   assign gnt_m  = sel ? gnt_b  : gnt_a;
   assign vld_m  = sel ? vld_b  : vld_a;
   assign out_m  = sel ? out_b  : out_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign lfsr_m = sel ? lfsr_b : lfsr_a;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [7:0] pick_rng(input int mode);
      if (mode == 0) return 8'd5;
      case ($urandom_range(0, 3))
         0:       return 8'($urandom_range(0, 3));
         1:       return 8'($urandom_range(4, 20));
         2:       return 8'($urandom_range(100, 140));
         default: return 8'($urandom);
      endcase
   endfunction

   // Called at posedge+1; returns in the first cycle after reset.
   task automatic do_reset();
      reset_n = 1'b0;
      req = '0;
      req_range = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Transaction model: at each idle decision point, pick the round-robin
   // winner, walk the upcoming LFSR values to find the accepted draw, and
   // schedule the grant cycle and busy window from that.
   task automatic run_rand(input int mode, input int ngoal, input int budget);
      logic [7:0] mlfsr, v;
      logic [NR-1:0] rq;
      logic [7:0] rngs [NR];
      int m_ptr, idle_from, g_cyc, g_w, g_res, g_rng;
      int busy_lo, busy_hi, exp_out, ngr, mt;
      int w, r, msk, cand, res, kk;
      bit done;
      mt = sel ? 1 : 16;
      do_reset();
      mlfsr = 8'h01; rq = '0; m_ptr = 0; idle_from = 0;
      g_cyc = -1; g_w = 0; g_res = 0; g_rng = 0;
      busy_lo = 1; busy_hi = 0; exp_out = 0; ngr = 0;
      for (int i = 0; i < NR; i++) rngs[i] = 8'd0;
      for (int c = 0; c < budget && ngr < ngoal; c++) begin
         if (c == g_cyc) exp_out = g_res;
         chk("lfsr", lfsr_m, mlfsr);
         chk("gnt", gnt_m, (c == g_cyc) ? (1 << g_w) : 0);
         chk("rnd_valid", vld_m, (c == g_cyc) ? 1 : 0);
         chk("rnd_out", out_m, exp_out);
         chk("busy", busy_m, (c >= busy_lo && c <= busy_hi) ? 1 : 0);
         if (c == g_cyc) begin
            if (g_rng != 0) chk("below_range", (out_m < g_rng) ? 1 : 0, 1);
            rq[g_w] = 1'b0;
            ngr++;
         end
         for (int i = 0; i < NR; i++) begin
            if (!rq[i] && $urandom_range(0, 1) == 1) begin
               rq[i] = 1'b1;
               rngs[i] = pick_rng(mode);
            end
         end
         req = rq;
         for (int i = 0; i < NR; i++) req_range[i*8 +: 8] = rngs[i];
         if (c >= idle_from && rq != '0) begin
            w = -1;
            for (int i = 0; i < NR; i++) begin
               if (w < 0 && rq[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
            end
            r = int'(rngs[w]);
            if (r == 0) msk = 255;
            else begin
               msk = 0;
               while (msk < r - 1) msk = msk * 2 + 1;
            end
            v = nxt(mlfsr);
            done = 1'b0; res = 0; kk = 0;
            for (int k = 0; k < mt && !done; k++) begin
               cand = int'(v) & msk;
               kk = k;
               if (r == 0 || cand < r) begin
                  res = cand; done = 1'b1;
               end else if (k == mt - 1) begin
                  res = cand - r; done = 1'b1;
               end
               v = nxt(v);
            end
            g_cyc = c + 2 + kk; g_w = w; g_res = res; g_rng = r;
            busy_lo = c + 1; busy_hi = g_cyc; idle_from = g_cyc + 1;
            m_ptr = (w + 1) % NR;
         end
         mlfsr = nxt(mlfsr);
         step();
      end
      chk("grant_count", ngr, ngoal);
      req = '0;
   endtask

   typedef struct {
      bit         rst;
      logic [3:0] rq;
      logic [31:0] rg;
      bit         chk;
      logic [7:0] lfsr;
      logic [3:0] gnt;
      bit         vld;
      logic [7:0] out;
      bit         busy;
   } vec_t;

   function automatic vec_t mk(bit rst, logic [3:0] rq, logic [31:0] rg, bit c,
                               logic [7:0] l, logic [3:0] g, bit vd,
                               logic [7:0] o, bit b);
      vec_t x;
      x.rst = rst; x.rq = rq; x.rg = rg; x.chk = c; x.lfsr = l;
      x.gnt = g; x.vld = vd; x.out = o; x.busy = b;
      return x;
   endfunction

   vec_t tbl [21];

   initial begin
      int last, idx, first;
      int seq [5];
      seq = '{0, 1, 2, 3, 0};
      // Each row: check outputs of this cycle, then drive its inputs.
      tbl[0]  = mk(1, 4'h0, 32'h0,        0, 8'h00, 4'h0, 0, 8'h00, 0);
      tbl[1]  = mk(0, 4'h0, 32'h0,        1, 8'h01, 4'h0, 0, 8'h00, 0);
      tbl[2]  = mk(0, 4'h0, 32'h0,        1, 8'h02, 4'h0, 0, 8'h00, 0);
      tbl[3]  = mk(0, 4'h0, 32'h0,        1, 8'h04, 4'h0, 0, 8'h00, 0);
      tbl[4]  = mk(0, 4'h0, 32'h0,        1, 8'h08, 4'h0, 0, 8'h00, 0);
      tbl[5]  = mk(0, 4'h0, 32'h0,        1, 8'h11, 4'h0, 0, 8'h00, 0);
      tbl[6]  = mk(0, 4'h0, 32'h0,        1, 8'h23, 4'h0, 0, 8'h00, 0);
      tbl[7]  = mk(0, 4'h0, 32'h0,        1, 8'h47, 4'h0, 0, 8'h00, 0);
      tbl[8]  = mk(0, 4'h0, 32'h0,        1, 8'h8E, 4'h0, 0, 8'h00, 0);
      tbl[9]  = mk(1, 4'h0, 32'h0,        1, 8'h1C, 4'h0, 0, 8'h00, 0);
      tbl[10] = mk(0, 4'h1, 32'h0,        1, 8'h01, 4'h0, 0, 8'h00, 0);
      tbl[11] = mk(0, 4'h1, 32'h0,        1, 8'h02, 4'h0, 0, 8'h00, 1);
      tbl[12] = mk(0, 4'h0, 32'h0,        1, 8'h04, 4'h1, 1, 8'h02, 1);
      tbl[13] = mk(0, 4'h2, 32'h100,      1, 8'h08, 4'h0, 0, 8'h02, 0);
      tbl[14] = mk(0, 4'h2, 32'h100,      1, 8'h11, 4'h0, 0, 8'h02, 1);
      tbl[15] = mk(0, 4'h0, 32'h0,        1, 8'h23, 4'h2, 1, 8'h00, 1);
      tbl[16] = mk(0, 4'h4, 32'h0005_0000, 1, 8'h47, 4'h0, 0, 8'h00, 0);
      tbl[17] = mk(0, 4'h4, 32'h0005_0000, 1, 8'h8E, 4'h0, 0, 8'h00, 1);
      tbl[18] = mk(0, 4'h4, 32'h0005_0000, 1, 8'h1C, 4'h0, 0, 8'h00, 1);
      tbl[19] = mk(0, 4'h0, 32'h0,        1, 8'h38, 4'h4, 1, 8'h04, 1);
      tbl[20] = mk(0, 4'h0, 32'h0,        1, 8'h71, 4'h0, 0, 8'h04, 0);

      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 21; i++) begin
         if (tbl[i].chk) begin
            chk($sformatf("vec%0d.lfsr", i), lfsr_a, tbl[i].lfsr);
            chk($sformatf("vec%0d.gnt", i), gnt_a, tbl[i].gnt);
            chk($sformatf("vec%0d.valid", i), vld_a, tbl[i].vld);
            chk($sformatf("vec%0d.out", i), out_a, tbl[i].out);
            chk($sformatf("vec%0d.busy", i), busy_a, tbl[i].busy);
         end
         reset_n = !tbl[i].rst;
         req = tbl[i].rq;
         req_range = tbl[i].rg;
         step();
      end

      // Round-robin with all requests held, full range.
      do_reset();
      req = 4'hF;
      idx = 0; last = -1; first = -1;
      for (int c = 0; c < 40 && idx < 5; c++) begin
         if (gnt_a != 4'h0) begin
            chk("rr.order", gnt_a, 1 << seq[idx]);
            chk("rr.valid", vld_a, 1);
            if (idx == 0) first = c;
            else chk("rr.spacing", c - last, 3);
            last = c;
            idx++;
         end
         step();
      end
      chk("rr.count", idx, 5);
      chk("rr.first", first, 2);

      // Range 1 always yields 0.
      do_reset();
      req = 4'hF;
      req_range = 32'h0101_0101;
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         if (vld_a) begin
            chk("rng1.out", out_a, 0);
            idx++;
         end
         step();
      end
      chk("rng1.count", idx, 6);

      // Winner drops its request in DRAW: no grant, pointer unchanged.
      do_reset();
      req = 4'h1;
      req_range = 32'h0;
      step();
      chk("abort.busy_draw", busy_a, 1);
      req = 4'h0;
      step();
      chk("abort.busy_idle", busy_a, 0);
      chk("abort.no_gnt", gnt_a, 0);
      step();
      chk("abort.no_gnt2", gnt_a, 0);
      req = 4'h3;
      step();
      chk("abort.redraw_busy", busy_a, 1);
      step();
      chk("abort.same_ptr", gnt_a, 4'h1);
      req = 4'h0;
      step();

      // Reset asserted while in DRAW.
      req = 4'h1;
      req_range = 32'h5;
      step();
      chk("rstdraw.busy", busy_a, 1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      req = 4'h0;
      chk("rstdraw.lfsr", lfsr_a, 8'h01);
      chk("rstdraw.gnt", gnt_a, 0);
      chk("rstdraw.busy0", busy_a, 0);
      chk("rstdraw.valid", vld_a, 0);
      chk("rstdraw.out", out_a, 0);
      step();
      chk("rstdraw.no_late_gnt", gnt_a, 0);

`ifdef RNG_ARB_RESEED_EN
      seed_load = 1'b1;
      seed_value = 8'h5A;
      step();
      chk("reseed.5A", lfsr_a, 8'h5A);
      seed_value = 8'h00;
      step();
      chk("reseed.zero", lfsr_a, 8'h01);
      seed_load = 1'b0;
      step();
      chk("reseed.advance", lfsr_a, 8'h02);
`endif

      sel = 1'b0;
      run_rand(0, 2000, 30000);
      run_rand(1, 800, 30000);
      sel = 1'b1;
      run_rand(0, 500, 10000);
      run_rand(1, 300, 10000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
